// File: rtl/shift_transfer_ctrl.sv
// Load/shift strobe sequencer for the serial-shift byte datapath, with a
// prescaled automatic BITS-step transfer mode and busy/done/progress status.
module shift_transfer_ctrl #(
    parameter int unsigned STEP_DIV = 25000000,
    parameter int unsigned BITS     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_req,
    input  logic       transmit_req,
    input  logic       auto_req,
    input  logic       abort,
    output logic       load_en,
    output logic       shift_en,
    output logic [3:0] shift_count,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int unsigned PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned CW = 4;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [CW-1:0]   count_d;
    logic            load_d;
    logic            shift_d;

    // Next-state and next-output decode; status flags follow the next state
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = shift_count;
        load_d  = 1'b0;
        shift_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write_req) begin
                    load_d = 1'b1;
                end else if (transmit_req) begin
                    shift_d = 1'b1;
                end else if (auto_req) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                // abort beats both completion and a coincident terminal count
                if (abort) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (shift_count == COUNT_LAST) begin
                    state_d = ST_DONE;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    shift_d = 1'b1;
                    count_d = shift_count + CW'(1);
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            shift_count <= '0;
            load_en     <= 1'b0;
            shift_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            shift_count <= count_d;
            load_en     <= load_d;
            shift_en    <= shift_d;
            busy        <= (state_d == ST_RUN);
            done        <= (state_d == ST_DONE);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_shift_transfer_ctrl.sv
// Scoreboard bench for shift_transfer_ctrl: expected strobe events are queued
// with their cycle when requests are driven, and matched as the DUT emits them.
module tb_shift_transfer_ctrl;

    localparam int unsigned STEP_DIV = 4;
    localparam int unsigned BITS     = 8;
    localparam int EV_LOAD  = 0;
    localparam int EV_SHIFT = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int          kind;
        int unsigned cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic       tx;
    logic       au;
    logic       ab;
    logic       load_en;
    logic       shift_en;
    logic [3:0] shift_count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_err;
    ev_t         sbq[$];

    shift_transfer_ctrl #(.STEP_DIV(STEP_DIV), .BITS(BITS)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .write_req    (wr),
        .transmit_req (tx),
        .auto_req     (au),
        .abort        (ab),
        .load_en      (load_en),
        .shift_en     (shift_en),
        .shift_count  (shift_count),
        .busy         (busy),
        .done         (done),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int unsigned at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic pop_match(input int kind);
        ev_t e;
        check("sb_nonempty", (sbq.size() > 0) ? 1 : 0, 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
        end
    endtask

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_en && shift_en) check("load_shift_excl", 1, 0);
            if (load_en)  pop_match(EV_LOAD);
            if (shift_en) pop_match(EV_SHIFT);
            if (done)     pop_match(EV_DONE);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            wr = 0; tx = 0; au = 0; ab = 0;
        end
    endtask

    initial begin
        int unsigned n0;
        cyc = 0; n_vec = 0; n_err = 0;
        rst_n = 0; wr = 0; tx = 0; au = 0; ab = 0;
        repeat (3) tick();
        check("rst_load", load_en, 0);
        check("rst_shift", shift_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);
        check("rst_count", shift_count, 0);
        @(negedge clk);
        rst_n = 1;
        idle_cycles(2);

        // write_req and transmit_req together: load wins, shift dropped
        wr = 1; tx = 1;
        push(EV_LOAD, cyc + 1);
        idle_cycles(3);

        // lone transmit_req, with abort high having no effect in IDLE
        tx = 1; ab = 1;
        push(EV_SHIFT, cyc + 1);
        idle_cycles(3);
        check("idle_abort_state", state, 0);

        // full automatic transfer with ignored requests, then DONE-cycle drop
        n0 = cyc;
        au = 1;
        for (int i = 0; i < int'(BITS); i++) push(EV_SHIFT, n0 + 5 + 4 * i);
        push(EV_DONE, n0 + 34);
        for (int k = 1; k <= 38; k++) begin
            tick();
            wr = 0; tx = 0; au = 0; ab = 0;
            if (k == 1)  begin check("run_busy_k1", busy, 1); check("run_state_k1", state, 1); end
            if (k == 13) check("run_count_k13", shift_count, 3);
            if (k == 33) begin check("run_busy_k33", busy, 1); check("run_count_k33", shift_count, 8); end
            if (k == 34) begin
                check("done_busy", busy, 0);
                check("done_state", state, 2);
                check("done_count", shift_count, 8);
            end
            if (k == 35) begin check("post_state", state, 0); check("post_count", shift_count, 8); end
            if (k == 6)  tx = 1;
            if (k == 12) wr = 1;
            if (k == 20) au = 1;
            if (k == 34) tx = 1;
            if (k == 35) begin tx = 1; push(EV_SHIFT, n0 + 36); end
        end

        // abort coincident with the 4th terminal count
        n0 = cyc;
        au = 1;
        push(EV_SHIFT, n0 + 5);
        push(EV_SHIFT, n0 + 9);
        push(EV_SHIFT, n0 + 13);
        for (int k = 1; k <= 40; k++) begin
            tick();
            wr = 0; tx = 0; au = 0; ab = 0;
            if (k == 16) ab = 1;
            if (k == 17) begin
                check("abort_state", state, 0);
                check("abort_busy", busy, 0);
                check("abort_count", shift_count, 3);
            end
            if (k == 40) check("abort_count_hold", shift_count, 3);
        end

        // reset asserted mid-run with three shifts done
        n0 = cyc;
        au = 1;
        push(EV_SHIFT, n0 + 5);
        push(EV_SHIFT, n0 + 9);
        push(EV_SHIFT, n0 + 13);
        for (int k = 1; k <= 14; k++) begin
            tick();
            wr = 0; tx = 0; au = 0; ab = 0;
        end
        check("pre_rst_count", shift_count, 3);
        check("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        check("mid_rst_count", shift_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_shift", shift_en, 0);
        check("mid_rst_done", done, 0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1;
        idle_cycles(40);
        check("post_rst_state", state, 0);
        check("post_rst_busy", busy, 0);

        check("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_transfer_ctrl.md
Name: shift_transfer_ctrl

Overview:
- Sequencer for the red/green serial-shift byte datapath on the board.
- Turns synchronized button pulses into single-cycle load/shift strobes for that datapath.
- Adds an automatic mode that performs a full BITS-step transfer at a fixed, prescaled rate.
- Reports busy, done and progress for LED/seven-segment display.

Parameters:
- STEP_DIV, 25000000: clock cycles between automatic shift strobes (≥2); benches override to 4.
- BITS, 8: number of shift strobes in one automatic transfer (1..15).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- write_req  input  1  one-cycle pulse (synchronized button): load datapath from switches
- transmit_req  input  1  one-cycle pulse: single manual shift
- auto_req  input  1  one-cycle pulse: start automatic BITS-step transfer
- abort  input  1  level; cancels an automatic transfer
- load_en  output  1  one-cycle load strobe to datapath
- shift_en  output  1  one-cycle shift strobe to datapath
- shift_count  output  4  shifts completed in current/last automatic transfer
- busy  output  1  high while automatic transfer in progress
- done  output  1  one-cycle pulse on automatic transfer completion
- state  output  2  FSM state code for debug LEDs (IDLE=0, RUN=1, DONE=2)

Behaviour:
- Clocking and reset
  - Single clock domain. All outputs registered.
  - Reset asserted (reset=0) asynchronously forces: IDLE, load_en=0, shift_en=0, shift_count=0, busy=0, done=0, state=0, prescaler=0.
  - Reset mid-transfer abandons the transfer; no done pulse.
- IDLE
  - A request sampled at edge k produces its strobe during cycle k+1 (latency 1).
  - Priority for simultaneous requests: write_req > transmit_req > auto_req; lower-priority requests in the same cycle are dropped, not queued.
  - write_req: load_en=1 for one cycle.
  - transmit_req: shift_en=1 for one cycle.
  - auto_req alone: enter RUN; shift_count<=0, prescaler<=0, busy<=1.
  - abort has no effect in IDLE.
- RUN
  - Prescaler counts 0..STEP_DIV-1. At terminal count: shift_en=1 for one cycle, shift_count increments, prescaler wraps to 0.
  - First shift_en occurs STEP_DIV cycles after RUN entry; consecutive shift_en strobes are STEP_DIV cycles apart.
  - write_req, transmit_req and auto_req are ignored (dropped) while in RUN.
  - abort=1 sampled: go to IDLE next cycle, busy<=0, no shift_en that cycle, no done; shift_count holds its partial value.
  - abort and the prescaler terminal count in the same cycle: abort wins, no shift.
  - The BITS-th shift: shift_en=1 in that cycle, then go to DONE.
- DONE
  - Lasts exactly one cycle: done=1, busy=0, then return to IDLE unconditionally.
  - Requests arriving during the DONE cycle are dropped.
- shift_count
  - Holds its value after completion or abort until the next auto_req acceptance or reset.
  - Never exceeds BITS.
- load_en and shift_en are never high in the same cycle.

Test Plan (STEP_DIV=4, BITS=8):
- Reset low mid-RUN with shift_count=3 -> all outputs 0 immediately, no later done; state=0.
- write_req and transmit_req pulsed in the same cycle in IDLE -> load_en high exactly one cycle at k+1; shift_en stays 0.
- auto_req at cycle 0 -> busy=1 from cycle 1; shift_en at cycles 5,9,...,33 (8 pulses); done=1 at cycle 34; shift_count=8; busy=0 from cycle 34.
- During RUN, pulse transmit_req, write_req and a second auto_req -> no extra strobes; pulse timing unchanged; exactly 8 shift_en pulses total.
- abort raised after the 3rd shift_en, coincident with the next prescaler terminal count -> no 4th shift_en, no done; state=0 next cycle; shift_count=3.
- transmit_req in the DONE cycle, then transmit_req one cycle later in IDLE -> first request dropped; single shift_en one cycle after the second.
